// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage: operands and op in, write-back and stall request out.
// No internal latency or flow control; ctrl_stall carries the pipeline hold vector from ctrl.
interface ex_stage_if #(
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6
);
  logic [3:0]         aluop;
  logic [DATA_W-1:0]  reg1;
  logic [DATA_W-1:0]  reg2;
  logic [4:0]         waddr_i;
  logic               we_i;
  logic [STALL_W-1:0] ctrl_stall;
  logic [4:0]         ex_waddr;
  logic               ex_we;
  logic [DATA_W-1:0]  ex_wdata;
  logic               stallreq_ex;

  modport master (
    output aluop, reg1, reg2, waddr_i, we_i, ctrl_stall,
    input  ex_waddr, ex_we, ex_wdata, stallreq_ex
  );

  modport slave (
    input  aluop, reg1, reg2, waddr_i, we_i, ctrl_stall,
    output ex_waddr, ex_we, ex_wdata, stallreq_ex
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/MUL, iterative restoring divider (33 stall cycles, 1 for divide-by-zero).
// Backpressure: raises stallreq_ex while dividing; a finished result is held in DONE while ctrl_stall[3] is set.
module ex_stage #(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SLTU = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8;
  localparam logic [3:0] OP_SRL  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_DIV  = 4'hC;
  localparam logic [3:0] OP_DIVU = 4'hD;
  localparam logic [3:0] OP_REM  = 4'hE;
  localparam logic [3:0] OP_REMU = 4'hF;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  div_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvsr;
  logic              q_neg;
  logic              r_neg;

  logic              is_div;
  logic              div_signed;
  logic              want_rem;
  logic              ex_hold;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_abs;
  logic [DATA_W-1:0] b_abs;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] mul_res;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] quo_step;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] res;
  logic              stall;
  logic              unused_stall;

  assign is_div     = (bus.aluop == OP_DIV) || (bus.aluop == OP_DIVU) ||
                      (bus.aluop == OP_REM) || (bus.aluop == OP_REMU);
  assign div_signed = (bus.aluop == OP_DIV) || (bus.aluop == OP_REM);
  assign want_rem   = (bus.aluop == OP_REM) || (bus.aluop == OP_REMU);
  assign ex_hold    = bus.ctrl_stall[3];
  assign unused_stall = ^bus.ctrl_stall;

  assign a_neg   = div_signed && bus.reg1[DATA_W-1];
  assign b_neg   = div_signed && bus.reg2[DATA_W-1];
  assign a_abs   = a_neg ? -bus.reg1 : bus.reg1;
  assign b_abs   = b_neg ? -bus.reg2 : bus.reg2;
  assign shamt   = bus.reg2[SH_W-1:0];
  assign mul_res = bus.reg1 * bus.reg2;

  // Restoring step: the partial remainder stays below the divisor, so the
  // top bit of the W+1-bit trial difference is exactly the borrow.
  always_comb begin
    trial = {rem, quo[DATA_W-1]} - {1'b0, dvsr};
    if (!trial[DATA_W]) begin
      rem_step = trial[DATA_W-1:0];
      quo_step = {quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_step = {rem[DATA_W-2:0], quo[DATA_W-1]};
      quo_step = {quo[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvsr  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_div && !ex_hold) begin
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            cnt   <= '0;
            if (bus.reg2 == '0) begin
              quo   <= '1;
              rem   <= bus.reg1;
              state <= DONE;
            end else begin
              quo   <= a_abs;
              rem   <= '0;
              dvsr  <= b_abs;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!is_div) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              quo   <= q_neg ? -quo_step : quo_step;
              rem   <= r_neg ? -rem_step : rem_step;
              state <= DONE;
            end else begin
              quo <= quo_step;
              rem <= rem_step;
            end
          end
        end
        DONE: begin
          if (!is_div || !ex_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    case (bus.aluop)
      OP_NOP:  alu_res = '0;
      OP_ADD:  alu_res = bus.reg1 + bus.reg2;
      OP_SUB:  alu_res = bus.reg1 - bus.reg2;
      OP_AND:  alu_res = bus.reg1 & bus.reg2;
      OP_OR:   alu_res = bus.reg1 | bus.reg2;
      OP_XOR:  alu_res = bus.reg1 ^ bus.reg2;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(bus.reg1) < $signed(bus.reg2))};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (bus.reg1 < bus.reg2)};
      OP_SLL:  alu_res = bus.reg1 << shamt;
      OP_SRL:  alu_res = bus.reg1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.reg1) >>> shamt);
      OP_MUL:  alu_res = mul_res;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res = '0;
      default: alu_res = '0;
    endcase

    // Stall follows the live op, so a flush drops it in the same cycle.
    stall = 1'b0;
    res   = alu_res;
    if (is_div) begin
      res = '0;
      case (state)
        IDLE:    stall = !ex_hold;
        BUSY:    stall = 1'b1;
        DONE:    res   = want_rem ? rem : quo;
        default: stall = 1'b0;
      endcase
    end
  end

  assign bus.ex_waddr    = rst ? 5'd0 : bus.waddr_i;
  assign bus.ex_we       = rst ? 1'b0 : (bus.we_i && (bus.aluop != OP_NOP) && !stall);
  assign bus.ex_wdata    = rst ? '0 : res;
  assign bus.stallreq_ex = rst ? 1'b0 : stall;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: table of single-cycle ALU vectors plus hand-written divider sequences.
module tb_ex_stage;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ex_stage_if #(.DATA_W(32), .STALL_W(6)) bus();

  ex_stage #(.DATA_W(32), .DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] exp_d;
    logic        exp_we;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa, input logic we);
    bus.aluop   = op;
    bus.reg1    = a;
    bus.reg2    = b;
    bus.waddr_i = wa;
    bus.we_i    = we;
  endtask

  // Drives a div-class op from IDLE, counts stall cycles, checks the result cycle,
  // then takes the DONE->IDLE edge (ctrl_stall is 0).
  task automatic run_div(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stalls, input logic [31:0] exp_res);
    int n;
    int bad_we;
    drive(op, a, b, 5'd9, 1'b1);
    n = 0;
    bad_we = 0;
    #1;
    while (bus.stallreq_ex === 1'b1 && n < 100) begin
      if (bus.ex_we !== 1'b0) bad_we++;
      n++;
      @(posedge clk);
      #2;
    end
    check({name, "_stall_cycles"}, 32'(n), 32'(exp_stalls));
    check({name, "_we_during_stall"}, 32'(bad_we), 32'd0);
    check({name, "_result"}, bus.ex_wdata, exp_res);
    check({name, "_result_we"}, {31'd0, bus.ex_we}, 32'd1);
    check({name, "_result_waddr"}, {27'd0, bus.ex_waddr}, 32'd9);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{4'h1, 32'h7FFF_FFFF, 32'h0000_0001, 5'd5, 1'b1, 32'h8000_0000, 1'b1};
    vecs[1]  = '{4'h2, 32'h0000_0000, 32'h0000_0001, 5'd6, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[2]  = '{4'h3, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7, 1'b1, 32'hF000_F000, 1'b1};
    vecs[3]  = '{4'h4, 32'h0F0F_0000, 32'h0000_00F0, 5'd8, 1'b1, 32'h0F0F_00F0, 1'b1};
    vecs[4]  = '{4'h5, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 5'd9, 1'b0, 32'h5555_5555, 1'b0};
    vecs[5]  = '{4'h6, 32'hFFFF_FFFF, 32'h0000_0001, 5'd10, 1'b1, 32'h0000_0001, 1'b1};
    vecs[6]  = '{4'h6, 32'h0000_0001, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'h0000_0000, 1'b1};
    vecs[7]  = '{4'h7, 32'h0000_0001, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'h0000_0001, 1'b1};
    vecs[8]  = '{4'h7, 32'hFFFF_FFFF, 32'h0000_0001, 5'd11, 1'b1, 32'h0000_0000, 1'b1};
    vecs[9]  = '{4'h8, 32'h0000_0001, 32'h0000_0021, 5'd12, 1'b1, 32'h0000_0002, 1'b1};
    vecs[10] = '{4'h9, 32'h8000_0000, 32'h0000_001F, 5'd13, 1'b1, 32'h0000_0001, 1'b1};
    vecs[11] = '{4'hA, 32'h8000_0000, 32'h0000_001F, 5'd14, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[12] = '{4'hA, 32'h7FFF_FFFF, 32'h0000_0004, 5'd14, 1'b1, 32'h07FF_FFFF, 1'b1};
    vecs[13] = '{4'hB, 32'h0000_3039, 32'h0000_0064, 5'd15, 1'b1, 32'h0012_D644, 1'b1};
    vecs[14] = '{4'hB, 32'hFFFF_FFFF, 32'h0000_0003, 5'd16, 1'b1, 32'hFFFF_FFFD, 1'b1};
    vecs[15] = '{4'hB, 32'h0001_0000, 32'h0001_0000, 5'd17, 1'b1, 32'h0000_0000, 1'b1};
    vecs[16] = '{4'h0, 32'h0000_0005, 32'h0000_0006, 5'd18, 1'b1, 32'h0000_0000, 1'b0};

    rst = 1'b1;
    bus.ctrl_stall = 6'd0;
    drive(4'h1, 32'h1234_5678, 32'h1, 5'd7, 1'b1);
    tick();
    tick();
    check("reset_waddr", {27'd0, bus.ex_waddr}, 32'd0);
    check("reset_we", {31'd0, bus.ex_we}, 32'd0);
    check("reset_wdata", bus.ex_wdata, 32'd0);
    check("reset_stallreq", {31'd0, bus.stallreq_ex}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wa, vecs[i].we);
      #1;
      check($sformatf("vec%0d_wdata", i), bus.ex_wdata, vecs[i].exp_d);
      check($sformatf("vec%0d_we", i), {31'd0, bus.ex_we}, {31'd0, vecs[i].exp_we});
      check($sformatf("vec%0d_waddr", i), {27'd0, bus.ex_waddr}, {27'd0, vecs[i].wa});
      check($sformatf("vec%0d_stallreq", i), {31'd0, bus.stallreq_ex}, 32'd0);
      tick();
    end

    // Back-to-back divides, divide-by-zero and signed overflow.
    run_div("div_m7_2",    4'hC, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFD);
    run_div("rem_m7_2",    4'hE, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF);
    run_div("divu_100_0",  4'hD, 32'd100, 32'h0, 1, 32'hFFFF_FFFF);
    run_div("remu_100_0",  4'hF, 32'd100, 32'h0, 1, 32'd100);
    run_div("div_ovf",     4'hC, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000);
    run_div("rem_ovf",     4'hE, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0);
    run_div("div_7_m2",    4'hC, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
    run_div("rem_7_m2",    4'hE, 32'd7, 32'hFFFF_FFFE, 33, 32'd1);
    drive(4'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();

    // Result held in DONE across a downstream stall.
    drive(4'hC, 32'd100, 32'd7, 5'd4, 1'b1);
    n = 0;
    #1;
    while (bus.stallreq_ex === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #2;
    end
    check("hold_stall_cycles", 32'(n), 32'd33);
    bus.ctrl_stall = 6'b011111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("hold%0d_wdata", k), bus.ex_wdata, 32'd14);
      check($sformatf("hold%0d_stallreq", k), {31'd0, bus.stallreq_ex}, 32'd0);
      tick();
    end
    bus.ctrl_stall = 6'd0;
    #1;
    check("hold_release_wdata", bus.ex_wdata, 32'd14);
    tick();
    #1;
    check("hold_back_idle_restart", {31'd0, bus.stallreq_ex}, 32'd1);
    check("hold_back_idle_wdata", bus.ex_wdata, 32'd0);
    drive(4'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    tick();

    // Flush mid-division: stall drops at once and the next divide starts fresh.
    drive(4'hC, 32'd1000, 32'd10, 5'd3, 1'b1);
    for (int k = 0; k < 6; k++) tick();
    drive(4'h1, 32'd1, 32'd2, 5'd3, 1'b1);
    #1;
    check("flush_stallreq", {31'd0, bus.stallreq_ex}, 32'd0);
    check("flush_wdata", bus.ex_wdata, 32'd3);
    check("flush_we", {31'd0, bus.ex_we}, 32'd1);
    tick();
    run_div("after_flush_divu", 4'hD, 32'd9, 32'd3, 33, 32'd3);
    drive(4'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();

    // Reset at BUSY iteration 10 aborts the divide.
    drive(4'hD, 32'hFFFF_FFFF, 32'd3, 5'd21, 1'b1);
    for (int k = 0; k < 11; k++) tick();
    #1;
    check("pre_rst_busy", {31'd0, bus.stallreq_ex}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_stallreq", {31'd0, bus.stallreq_ex}, 32'd0);
    check("mid_rst_wdata", bus.ex_wdata, 32'd0);
    check("mid_rst_we", {31'd0, bus.ex_we}, 32'd0);
    check("mid_rst_waddr", {27'd0, bus.ex_waddr}, 32'd0);
    tick();
    check("post_rst_wdata", bus.ex_wdata, 32'd0);
    check("post_rst_stallreq", {31'd0, bus.stallreq_ex}, 32'd0);
    rst = 1'b0;
    run_div("reissue_divu", 4'hD, 32'hFFFF_FFFF, 32'd3, 33, 32'h5555_5555);
    drive(4'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
